// File: rtl/flits_buffer_collector.sv
// Receive-side flit reassembly into two ping-pong packet slots, with packet
// handoff to message_queue and credit return to the router.
`timescale 1ns/1ps
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif
`ifndef FLIT_TYPE_BITS
`define FLIT_TYPE_BITS 31:30
`endif
`ifndef MAX_PACKET_LENGHT
`define MAX_PACKET_LENGHT 4
`endif

module flits_buffer_collector #(
    parameter int N_BITS_FLIT_COUNTER   = 3,
    parameter int N_BITS_CREDIT_COUNTER = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [`FLIT_WIDTH-1:0]                      flit_i,
    input  logic                                        valid_flit_i,
    output logic                                        credit_o,
    output logic [`MAX_PACKET_LENGHT*`FLIT_WIDTH-1:0]   in_link_o,
    output logic [`MAX_PACKET_LENGHT-1:0]               in_sel_o,
    output logic                                        r_pkt_to_msg_o,
    input  logic                                        g_pkt_to_msg_i,
    output logic                                        protocol_error_o
);
    localparam int W  = `FLIT_WIDTH;
    localparam int L  = `MAX_PACKET_LENGHT;
    localparam int FW = N_BITS_FLIT_COUNTER;
    localparam int CW = N_BITS_CREDIT_COUNTER;
    localparam int IW = (L > 1) ? $clog2(L) : 1;

    localparam logic [1:0] T_BODY      = 2'b00;
    localparam logic [1:0] T_TAIL      = 2'b01;
    localparam logic [1:0] T_HEAD      = 2'b10;
    localparam logic [1:0] T_HEAD_TAIL = 2'b11;

    typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_FULL} slot_state_e;

    slot_state_e      state_q [2];
    slot_state_e      state_d [2];
    logic [FW-1:0]    cnt_q   [2];
    logic [FW-1:0]    cnt_d   [2];
    logic [W-1:0]     data_q  [2][L];
    logic [W-1:0]     data_d  [2][L];
    logic [L-1:0]     sel_q   [2];
    logic [L-1:0]     sel_d   [2];
    logic             fill_ptr_q, fill_ptr_d;
    logic             present_ptr_q, present_ptr_d;
    logic [CW-1:0]    pending_q, pending_d;
    logic             credit_q, credit_d;
    logic             r_q, r_d;
    logic             err_q, err_d;

    logic [CW-1:0]    added;
    logic [1:0]       flit_type;
    logic             is_head;
    logic             start_pkt;
    logic             drop;
    logic [IW-1:0]    idx;

    assign flit_type = flit_i[`FLIT_TYPE_BITS];
    assign is_head   = (flit_type == T_HEAD) || (flit_type == T_HEAD_TAIL);
    assign idx       = cnt_q[fill_ptr_q][IW-1:0];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        data_d        = data_q;
        sel_d         = sel_q;
        fill_ptr_d    = fill_ptr_q;
        present_ptr_d = present_ptr_q;
        added         = '0;
        start_pkt     = 1'b0;
        drop          = 1'b0;
        err_d         = 1'b0;

        if (g_pkt_to_msg_i && r_q) begin
            state_d[present_ptr_q] = S_EMPTY;
            added                  = CW'(cnt_q[present_ptr_q]);
            present_ptr_d          = ~present_ptr_q;
        end

        if (valid_flit_i) begin
            case (state_q[fill_ptr_q])
                S_EMPTY: begin
                    if (is_head) start_pkt = 1'b1;
                    else         drop      = 1'b1;
                end
                S_FILLING: begin
                    if (is_head) begin
                        // Restart: the abandoned partial packet's slots go back as credits.
                        err_d     = 1'b1;
                        added     = added + CW'(cnt_q[fill_ptr_q]);
                        start_pkt = 1'b1;
                    end else begin
                        if (cnt_q[fill_ptr_q] == FW'(L)) begin
                            drop = 1'b1;
                        end else begin
                            data_d[fill_ptr_q][idx] = flit_i;
                            sel_d[fill_ptr_q][idx]  = 1'b1;
                            cnt_d[fill_ptr_q]       = cnt_q[fill_ptr_q] + FW'(1);
                        end
                        if (flit_type == T_TAIL) begin
                            state_d[fill_ptr_q] = S_FULL;
                            fill_ptr_d          = ~fill_ptr_q;
                        end
                    end
                end
                default: drop = 1'b1;
            endcase
        end

        if (start_pkt) begin
            for (int k = 0; k < L; k++) data_d[fill_ptr_q][k] = '0;
            data_d[fill_ptr_q][0] = flit_i;
            sel_d[fill_ptr_q]     = {{(L-1){1'b0}}, 1'b1};
            cnt_d[fill_ptr_q]     = FW'(1);
            if (flit_type == T_HEAD_TAIL) begin
                state_d[fill_ptr_q] = S_FULL;
                fill_ptr_d          = ~fill_ptr_q;
            end else begin
                state_d[fill_ptr_q] = S_FILLING;
            end
        end

        if (drop) begin
            err_d = 1'b1;
            added = added + CW'(1);
        end

        credit_d  = (pending_q != '0);
        pending_d = pending_q + added - CW'(credit_d);
        r_d       = (state_d[present_ptr_d] == S_FULL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < 2; s++) begin
                state_q[s] <= S_EMPTY;
                cnt_q[s]   <= '0;
                sel_q[s]   <= '0;
                for (int k = 0; k < L; k++) data_q[s][k] <= '0;
            end
            fill_ptr_q    <= 1'b0;
            present_ptr_q <= 1'b0;
            pending_q     <= '0;
            credit_q      <= 1'b0;
            r_q           <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sel_q         <= sel_d;
            data_q        <= data_d;
            fill_ptr_q    <= fill_ptr_d;
            present_ptr_q <= present_ptr_d;
            pending_q     <= pending_d;
            credit_q      <= credit_d;
            r_q           <= r_d;
            err_q         <= err_d;
        end
    end

    generate
        for (genvar gi = 0; gi < L; gi++) begin : g_link
            assign in_link_o[gi*W +: W] = data_q[present_ptr_q][gi];
        end
    endgenerate

    assign in_sel_o         = sel_q[present_ptr_q];
    assign credit_o         = credit_q;
    assign r_pkt_to_msg_o   = r_q;
    assign protocol_error_o = err_q;

endmodule
